// File: rtl/core_cen_gen.sv
// core_cen_gen: multi-channel fractional clock-enable generator.
// Each channel runs a modulo-den phase accumulator stepped by num every
// refclk cycle and emits a one-cycle cen pulse on every wrap, so the
// long-run pulse rate is exactly f_refclk*num/den. A single pending
// config slot retunes one channel at a time, applied only on that
// channel's own pulse edge so no runt or double pulse is produced.
module core_cen_gen #(
  parameter int CHANNELS = 4,
  parameter int ACC_W = 16,
  parameter logic [CHANNELS*ACC_W-1:0] DEF_NUM   = {16'd1, 16'd1, 16'd1, 16'd1},
  parameter logic [CHANNELS*ACC_W-1:0] DEF_DEN   = {16'd18, 16'd18, 16'd3, 16'd1},
  parameter logic [CHANNELS*ACC_W-1:0] DEF_PHASE = {16'd9, 16'd0, 16'd0, 16'd0},
  parameter int LOCK_CYCLES = 64
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                sync,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  input  logic [ACC_W-1:0]    cfg_phase,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] cen,
  output logic                locked
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  // Pending config slot (one request in flight at a time)
  logic               pend_valid_reg;
  logic [2:0]         pend_ch_reg;
  logic [ACC_W-1:0]   pend_num_reg;
  logic [ACC_W-1:0]   pend_den_reg;
  logic [ACC_W-1:0]   pend_phase_reg;
  logic               cfg_err_reg;
  logic [LOCK_W-1:0]  lock_count_reg;

  // Per-channel apply strobes, gathered so the slot and lock counter see them
  logic [CHANNELS-1:0] apply;
  logic                any_apply;
  logic                xfer;
  logic                cfg_ok;

  assign cfg_ready = ~pend_valid_reg;
  assign cfg_err   = cfg_err_reg;
  assign locked    = (lock_count_reg == LOCK_W'(LOCK_CYCLES));
  assign xfer      = cfg_valid & cfg_ready;
  assign any_apply = |apply;

  // A request is only meaningful if the accumulator stays below den
  assign cfg_ok = (cfg_den != '0) && (cfg_num <= cfg_den) &&
                  (cfg_phase < cfg_den) && (int'(cfg_ch) < CHANNELS);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [ACC_W-1:0] acc_reg;
      logic [ACC_W-1:0] num_reg;
      logic [ACC_W-1:0] den_reg;
      logic [ACC_W-1:0] phase_reg;
      logic             cen_reg;
      logic [ACC_W:0]   sum;
      logic             idle;
      logic             hit;

      // One extra bit so acc+num never wraps before the compare
      assign sum  = {1'b0, acc_reg} + {1'b0, num_reg};
      assign idle = (num_reg == '0);
      assign hit  = ~idle && (sum >= {1'b0, den_reg});

      // Retune only on this channel's pulse edge, when it is stopped, or on sync
      assign apply[gi] = pend_valid_reg && (pend_ch_reg == 3'(gi)) &&
                         (sync || hit || idle);

      assign cen[gi] = cen_reg;

      // Accumulator step, realign on sync, and ratio swap on apply
      always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg   <= DEF_PHASE[gi*ACC_W +: ACC_W];
          num_reg   <= DEF_NUM[gi*ACC_W +: ACC_W];
          den_reg   <= DEF_DEN[gi*ACC_W +: ACC_W];
          phase_reg <= DEF_PHASE[gi*ACC_W +: ACC_W];
          cen_reg   <= 1'b0;
        end else if (apply[gi]) begin
          // The pulse for this edge still belongs to the old ratio
          num_reg   <= pend_num_reg;
          den_reg   <= pend_den_reg;
          phase_reg <= pend_phase_reg;
          acc_reg   <= pend_phase_reg;
          cen_reg   <= hit & ~sync;
        end else if (sync) begin
          acc_reg <= phase_reg;
          cen_reg <= 1'b0;
        end else if (hit) begin
          acc_reg <= ACC_W'(sum - {1'b0, den_reg});
          cen_reg <= 1'b1;
        end else begin
          acc_reg <= sum[ACC_W-1:0];
          cen_reg <= 1'b0;
        end
      end
    end
  endgenerate

  // Config slot: latch valid requests, flag rejected ones, clear on apply
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_reg <= 1'b0;
      pend_ch_reg    <= '0;
      pend_num_reg   <= '0;
      pend_den_reg   <= '0;
      pend_phase_reg <= '0;
      cfg_err_reg    <= 1'b0;
    end else begin
      if (any_apply) begin
        pend_valid_reg <= 1'b0;
      end
      if (xfer) begin
        if (cfg_ok) begin
          pend_valid_reg <= 1'b1;
          pend_ch_reg    <= cfg_ch;
          pend_num_reg   <= cfg_num;
          pend_den_reg   <= cfg_den;
          pend_phase_reg <= cfg_phase;
        end else begin
          cfg_err_reg <= 1'b1;
        end
      end
    end
  end

  // Lock counter: saturating count of undisturbed cycles
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_count_reg <= '0;
    end else if (sync || any_apply) begin
      lock_count_reg <= '0;
    end else if (lock_count_reg != LOCK_W'(LOCK_CYCLES)) begin
      lock_count_reg <= lock_count_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_core_cen_gen.sv
// tb_core_cen_gen: directed scenarios plus randomized config/sync traffic
// against a pulse-count reference model of core_cen_gen.
module tb_core_cen_gen;
  localparam int CH   = 4;
  localparam int W    = 16;
  localparam int LOCK = 64;

  logic          refclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sync = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [2:0]    cfg_ch = '0;
  logic [W-1:0]  cfg_num = '0;
  logic [W-1:0]  cfg_den = '0;
  logic [W-1:0]  cfg_phase = '0;
  logic          cfg_ready;
  logic          cfg_err;
  logic          locked;
  logic [CH-1:0] cen;

  always #5 refclk = ~refclk;

  core_cen_gen dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .sync     (sync),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_num  (cfg_num),
    .cfg_den  (cfg_den),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .cen      (cen),
    .locked   (locked)
  );

  // Reference model: channel k has seen m_n[k] edges since its last anchor
  // (reset, apply or sync); pulse count so far is floor((ph+n*num)/den).
  longint        m_num[CH], m_den[CH], m_ph[CH], m_n[CH];
  bit            m_pend;
  int            m_pch;
  longint        m_pnum, m_pden, m_pph;
  bit            m_err;
  int            m_since;
  logic [CH-1:0] m_cen;
  bit            m_xfer, m_applied;
  int            edge_no;
  int            n_assert, n_fail;

  function automatic bit fires(longint num, longint den, longint ph, longint n);
    if (num == 0) return 1'b0;
    return ((ph + n * num) / den) != ((ph + (n - 1) * num) / den);
  endfunction

  function void model_reset();
    for (int k = 0; k < CH; k++) begin
      m_num[k] = 1;
      m_den[k] = (k == 0) ? 1 : (k == 1) ? 3 : 18;
      m_ph[k]  = (k == 3) ? 9 : 0;
      m_n[k]   = 0;
    end
    m_pend = 0; m_pch = 0; m_pnum = 0; m_pden = 0; m_pph = 0;
    m_err = 0; m_since = 0; m_cen = '0; edge_no = 0;
    m_xfer = 0; m_applied = 0;
  endfunction

  function void model_edge();
    bit            pend_before;
    bit            f;
    logic [CH-1:0] nc;
    pend_before = m_pend;
    nc = '0;
    m_xfer = 0;
    m_applied = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    edge_no++;
    for (int k = 0; k < CH; k++) begin
      m_n[k]++;
      f = fires(m_num[k], m_den[k], m_ph[k], m_n[k]);
      nc[k] = sync ? 1'b0 : f;
      if (pend_before && m_pch == k && (sync || f || m_num[k] == 0)) begin
        m_num[k] = m_pnum; m_den[k] = m_pden; m_ph[k] = m_pph;
        m_n[k] = 0; m_pend = 0; m_applied = 1;
      end
    end
    if (sync) for (int k = 0; k < CH; k++) m_n[k] = 0;
    if (sync || m_applied) m_since = 0;
    else if (m_since < LOCK) m_since++;
    if (cfg_valid && !pend_before) begin
      m_xfer = 1;
      if (cfg_den != 0 && cfg_num <= cfg_den && cfg_phase < cfg_den && cfg_ch < CH) begin
        m_pend = 1; m_pch = int'(cfg_ch);
        m_pnum = longint'(cfg_num); m_pden = longint'(cfg_den); m_pph = longint'(cfg_phase);
      end else begin
        m_err = 1;
      end
    end
    m_cen = nc;
  endfunction

  task automatic check_outputs(input string tag);
    n_assert++;
    assert (cen === m_cen) else begin
      n_fail++; $error("FAIL %s cen observed=%b expected=%b", tag, cen, m_cen);
    end
    n_assert++;
    assert (cfg_ready === !m_pend) else begin
      n_fail++; $error("FAIL %s cfg_ready observed=%b expected=%b", tag, cfg_ready, !m_pend);
    end
    n_assert++;
    assert (cfg_err === m_err) else begin
      n_fail++; $error("FAIL %s cfg_err observed=%b expected=%b", tag, cfg_err, m_err);
    end
    n_assert++;
    assert (locked === (m_since >= LOCK)) else begin
      n_fail++; $error("FAIL %s locked observed=%b expected=%b", tag, locked, (m_since >= LOCK));
    end
  endtask

  task automatic step();
    @(posedge refclk);
    model_edge();
    #1;
    check_outputs($sformatf("edge%0d", edge_no));
  endtask

  task automatic send_cfg(input int ch, input int num, input int den, input int ph);
    cfg_ch = 3'(ch); cfg_num = W'(num); cfg_den = W'(den); cfg_phase = W'(ph);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    $display("cfg ch=%0d num=%0d den=%0d phase=%0d -> %s", ch, num, den, ph,
             m_xfer ? (m_pend ? "accepted" : "rejected") : "held off");
  endtask

  // Asynchronous reset mid-cycle; cen must fall without waiting for an edge
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_assert++;
    assert (cen === '0) else begin
      n_fail++; $error("FAIL async_reset_cen observed=%b expected=0", cen);
    end
    check_outputs("async_reset");
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Default-ratio pulse counts over 54 edges and lock time after release
  task automatic run_defaults(input string tag);
    int c0, c1, c2, c3, first_lock;
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; first_lock = -1;
    for (int i = 1; i <= 70; i++) begin
      step();
      if (i <= 54) begin
        c0 += int'(cen[0]); c1 += int'(cen[1]); c2 += int'(cen[2]); c3 += int'(cen[3]);
      end
      if (locked === 1'b1 && first_lock < 0) first_lock = edge_no;
    end
    n_assert++;
    assert (c0 === 54) else begin n_fail++; $error("FAIL %s ch0_count observed=%0d expected=54", tag, c0); end
    n_assert++;
    assert (c1 === 18) else begin n_fail++; $error("FAIL %s ch1_count observed=%0d expected=18", tag, c1); end
    n_assert++;
    assert (c2 === 3) else begin n_fail++; $error("FAIL %s ch2_count observed=%0d expected=3", tag, c2); end
    n_assert++;
    assert (c3 === 3) else begin n_fail++; $error("FAIL %s ch3_count observed=%0d expected=3", tag, c3); end
    n_assert++;
    assert (first_lock === 64) else begin n_fail++; $error("FAIL %s lock_edge observed=%0d expected=64", tag, first_lock); end
    $display("%s: default ratios run for 70 edges", tag);
  endtask

  initial begin
    int cnt, bad, last, ready_low, p1, p2, lock_edge, first3, guard;
    n_assert = 0;
    n_fail = 0;
    model_reset();

    // Reset state and default ratios
    repeat (3) @(posedge refclk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
    run_defaults("defaults");

    // Fractional 2/7 on ch1: 200 pulses per 700 cycles, gaps of 3 or 4
    send_cfg(1, 2, 7, 0);
    guard = 0;
    while (m_pend && guard < 10) begin step(); guard++; end
    n_assert++;
    assert (cfg_ready === 1'b1) else begin n_fail++; $error("FAIL frac_apply cfg_ready observed=%b expected=1", cfg_ready); end
    cnt = 0; bad = 0; last = -1;
    for (int i = 1; i <= 700; i++) begin
      step();
      if (cen[1] === 1'b1) begin
        if (last >= 0 && (i - last < 3 || i - last > 4)) bad++;
        last = i;
        cnt++;
      end
    end
    n_assert++;
    assert (cnt === 200) else begin n_fail++; $error("FAIL frac_count observed=%0d expected=200", cnt); end
    n_assert++;
    assert (bad === 0) else begin n_fail++; $error("FAIL frac_spacing bad_gaps observed=%0d expected=0", bad); end

    // Glitch-free retune of ch2 from 1/18 to 1/4 at mid-period
    do_reset();
    repeat (8) step();
    send_cfg(2, 1, 4, 0);
    p1 = -1; p2 = -1; ready_low = 0; lock_edge = -1;
    if (cfg_ready === 1'b0) ready_low++;
    while (edge_no < 90) begin
      step();
      if (cfg_ready === 1'b0) ready_low++;
      if (cen[2] === 1'b1) begin
        if (p1 < 0) p1 = edge_no;
        else if (p2 < 0) p2 = edge_no;
      end
      if (edge_no > 18 && locked === 1'b1 && lock_edge < 0) lock_edge = edge_no;
    end
    n_assert++;
    assert (p1 === 18) else begin n_fail++; $error("FAIL retune_apply_pulse observed=%0d expected=18", p1); end
    n_assert++;
    assert (p2 === 22) else begin n_fail++; $error("FAIL retune_next_pulse observed=%0d expected=22", p2); end
    n_assert++;
    assert (ready_low === 9) else begin n_fail++; $error("FAIL retune_ready_low observed=%0d expected=9", ready_low); end
    n_assert++;
    assert (lock_edge === 82) else begin n_fail++; $error("FAIL retune_relock observed=%0d expected=82", lock_edge); end

    // Invalid configs are consumed and flagged; a later valid one is taken
    send_cfg(0, 5, 4, 0);
    n_assert++;
    assert (cfg_err === 1'b1) else begin n_fail++; $error("FAIL invalid_num_err observed=%b expected=1", cfg_err); end
    send_cfg(1, 1, 0, 0);
    n_assert++;
    assert (cfg_ready === 1'b1) else begin n_fail++; $error("FAIL invalid_den_ready observed=%b expected=1", cfg_ready); end
    send_cfg(6, 1, 4, 0);
    n_assert++;
    assert (cfg_ready === 1'b1) else begin n_fail++; $error("FAIL invalid_ch_ready observed=%b expected=1", cfg_ready); end
    repeat (5) step();
    send_cfg(0, 1, 2, 0);
    n_assert++;
    assert (cfg_ready === 1'b0) else begin n_fail++; $error("FAIL valid_after_invalid_ready observed=%b expected=0", cfg_ready); end
    repeat (6) step();

    // sync with a pending ch3 config: all cen low, slot applied, new phase used
    guard = 0;
    while (!m_cen[3] && guard < 40) begin step(); guard++; end
    n_assert++;
    assert (guard < 40) else begin n_fail++; $error("FAIL wait_ch3_pulse observed=%0d expected<40", guard); end
    send_cfg(3, 1, 5, 2);
    repeat (3) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    n_assert++;
    assert (cen === '0) else begin n_fail++; $error("FAIL sync_cen observed=%b expected=0", cen); end
    n_assert++;
    assert (cfg_ready === 1'b1) else begin n_fail++; $error("FAIL sync_slot_clear observed=%b expected=1", cfg_ready); end
    first3 = -1;
    for (int i = 1; i <= 70; i++) begin
      step();
      if (cen[3] === 1'b1 && first3 < 0) first3 = i;
    end
    n_assert++;
    assert (first3 === 3) else begin n_fail++; $error("FAIL sync_new_phase_pulse observed=%0d expected=3", first3); end

    // Reset mid-period with a pending config, then defaults again
    send_cfg(2, 1, 9, 3);
    guard = 0;
    while (m_cen == '0 && guard < 4) begin step(); guard++; end
    do_reset();
    run_defaults("after_reset");

    // Randomized config traffic with occasional sync
    for (int i = 0; i < 1500; i++) begin
      if (!cfg_valid && $urandom_range(0, 7) == 0) begin
        cfg_ch    = 3'($urandom_range(0, 4));
        cfg_den   = W'($urandom_range(0, 12));
        cfg_num   = W'($urandom_range(0, int'(cfg_den) + 1));
        cfg_phase = W'($urandom_range(0, int'(cfg_den)));
        cfg_valid = 1'b1;
      end
      sync = ($urandom_range(0, 59) == 0);
      step();
      if (m_xfer) begin
        $display("rand cfg ch=%0d num=%0d den=%0d phase=%0d -> %s", cfg_ch, cfg_num,
                 cfg_den, cfg_phase, m_pend ? "accepted" : "rejected");
        cfg_valid = 1'b0;
      end
    end
    sync = 1'b0;
    cfg_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
